mem_req_fifo: RTL

MEM_REQ_FIFO -- requirements
Module: mem_req_fifo

---
 rtl/mem_pkg.sv | 22 ++
 rtl/mem_fifo_ram.sv | 33 +++
 rtl/mem_req_fifo.sv | 103 ++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared memory request definitions used by the request FIFO and the memory shim.
package mem_pkg;

  localparam int CMD_W   = 2;
  localparam int ADDR_W  = 22;
  localparam int DATA_W  = 64;
  localparam int ENTRY_W = CMD_W + ADDR_W + DATA_W;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOOP    = 2'd0,
    CMD_REFRESH = 2'd1,
    CMD_READ    = 2'd2,
    CMD_WRITE   = 2'd3
  } mem_cmd_e;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dta;
  } mem_req_t;

endpackage

// File: rtl/mem_fifo_ram.sv
// Simple dual-port storage with a registered, enable-gated read port (block RAM style).
module mem_fifo_ram
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 4,
  parameter int WIDTH     = ENTRY_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_BITS-1:0] wr_addr,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 rd_en,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data
);

  logic [WIDTH-1:0] mem [2**ADDR_BITS];
  logic [WIDTH-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Output register only loads on a read, so it holds the last popped entry.
  always_ff @(posedge clk) begin
    if (!rst_n)     rd_data_reg <= '0;
    else if (rd_en) rd_data_reg <= mem[rd_addr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/mem_req_fifo.sv
// Request FIFO between the MPEG2 core and the memory shim; pointer, level and flag control.
module mem_req_fifo
  import mem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int AF_MARGIN  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [CMD_W-1:0]      wr_cmd,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_dta,
  output logic                  wr_full,
  output logic                  wr_almost_full,
  input  logic                  rd_en,
  output logic [CMD_W-1:0]      rd_cmd,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_dta,
  output logic                  rd_valid,
  output logic                  rd_empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow
);

  localparam int                  DEPTH      = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LEVEL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0] AF_LEVEL   = (DEPTH_LOG2+1)'(DEPTH - AF_MARGIN);
  localparam logic [DEPTH_LOG2:0] LVL_ONE    = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  logic [DEPTH_LOG2-1:0] wr_ptr_reg, wr_ptr_next;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg, rd_ptr_next;
  logic [DEPTH_LOG2:0]   level_reg, level_next;
  logic                  full_reg, empty_reg, af_reg;
  logic                  overflow_reg, overflow_next;
  logic                  rd_valid_reg;
  logic                  push, pop;
  mem_req_t              wr_entry, rd_entry;

  // Flags come from the current registered level, so a pop never frees room for a same-cycle push.
  always_comb begin
    push          = wr_en && !full_reg;
    pop           = rd_en && !empty_reg;
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    level_next    = level_reg;
    overflow_next = overflow_reg || (wr_en && full_reg);
    if (push) wr_ptr_next = wr_ptr_reg + PTR_ONE;
    if (pop)  rd_ptr_next = rd_ptr_reg + PTR_ONE;
    if (push && !pop)      level_next = level_reg + LVL_ONE;
    else if (pop && !push) level_next = level_reg - LVL_ONE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      af_reg       <= 1'b0;
      overflow_reg <= 1'b0;
      rd_valid_reg <= 1'b0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      level_reg    <= level_next;
      full_reg     <= (level_next == FULL_LEVEL);
      empty_reg    <= (level_next == '0);
      af_reg       <= (level_next >= AF_LEVEL);
      overflow_reg <= overflow_next;
      rd_valid_reg <= pop;
    end
  end

  assign wr_entry = '{cmd: wr_cmd, addr: wr_addr, dta: wr_dta};

  mem_fifo_ram #(
    .ADDR_BITS (DEPTH_LOG2),
    .WIDTH     (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push && rst_n),
    .wr_addr (wr_ptr_reg),
    .wr_data (wr_entry),
    .rd_en   (pop && rst_n),
    .rd_addr (rd_ptr_reg),
    .rd_data (rd_entry)
  );

  assign wr_full        = full_reg;
  assign wr_almost_full = af_reg;
  assign rd_empty       = empty_reg;
  assign level          = level_reg;
  assign overflow       = overflow_reg;
  assign rd_valid       = rd_valid_reg;
  assign rd_cmd         = rd_entry.cmd;
  assign rd_addr        = rd_entry.addr;
  assign rd_dta         = rd_entry.dta;

endmodule
